decode_fetch_sequencer: RTL and testbench
=========================================

Name: decode_fetch_sequencer

Overview:
- Byte-serial front end for the decoder.
- Accepts a stream of raw x86 instruction bytes, strips and records legacy prefixes, and detects the 0x0F escape.
- Packs the remaining opcode/ModRM/SIB/disp/imm bytes into the 88-bit `unescaped_instr` and `is_2byte` form consumed by `decode_opc_phase2`.
- Presents one instruction per valid/ready handshake and flags malformed or over-long encodings.

Parameters:
- MAX_LEN, 15: maximum total instruction length in bytes, prefixes and escape included.
- BODY_BYTES, 11: capacity of the unescaped body buffer; `unescaped_instr` width is 8*BODY_BYTES.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_byte/in_last are valid.
- in_ready  output  1  sequencer accepts a byte this cycle.
- in_byte  input  8  raw instruction byte.
- in_last  input  1  in_byte is the final byte of the current instruction.
- out_valid  output  1  packed instruction available.
- out_ready  input  1  downstream consumes the packed instruction.
- unescaped_instr  output  88  body bytes; body byte k at [8k+7:8k]; unused bytes are 0.
- is_2byte  output  1  0x0F escape was present.
- pfx_opsize  output  1  0x66 seen.
- pfx_addrsize  output  1  0x67 seen.
- pfx_lock  output  1  0xF0 seen.
- pfx_rep  output  2  0 none, 1 = F3, 2 = F2; last rep-class prefix wins.
- pfx_seg  output  3  0 none, 1 ES(26), 2 CS(2E), 3 SS(36), 4 DS(3E), 5 FS(64), 6 GS(65); last wins.
- instr_len  output  4  total bytes accepted for this instruction (1..15).
- err  output  1  instruction malformed; all other payload outputs are don't-care.

Behaviour:
- **Handshakes**
  - Input byte transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- **States**
  - S_PFX (reset state): in_ready=1.
    - Prefix byte: update prefix fields.
    - 0x0F: set is_2byte, go to S_BODY.
    - Any other byte: write body[0], body count=1, go to S_BODY.
  - S_BODY: in_ready=1. Each byte is written to body[count], then count increments.
  - S_DRAIN: in_ready=1. Bytes are discarded until in_last.
  - S_HOLD: in_ready=0, out_valid=1. Outputs are stable until the handshake.
    - On the handshake, clear all payload registers and go to S_PFX.
- **Transition to S_HOLD**
  - Any accepted byte with in_last=1 moves to S_HOLD in the next cycle, unless an error rule applies.
  - Latency from the last input byte to out_valid is 1 cycle.
- **Error rules** (err registered, sticky until the output handshake)
  - in_last on a prefix byte or on 0x0F (no opcode) → S_HOLD with err=1.
  - Body count would exceed BODY_BYTES → err=1.
  - Total accepted bytes would exceed MAX_LEN → err=1.
  - For both count rules: go to S_DRAIN if the offending byte has in_last=0, else S_HOLD.
  - S_DRAIN + in_last → S_HOLD with err=1.
- **Byte classification**
  - A second 0x0F after the escape is a body byte; there is no 3-byte escape handling.
  - Prefix bytes after the escape or after the first body byte are body bytes.
- **instr_len**
  - Counts every accepted byte, including drained ones, saturating at 15.
  - Its value with err=1 is don't-care.
- **Simultaneous events**
  - In S_HOLD, in_ready=0, so no new byte can overlap an output transfer.
  - There is no bypass: the first byte of the next instruction is accepted the cycle after the handshake.
- **Reset**
  - rst asserted at any time, including mid-instruction or in S_HOLD, immediately forces S_PFX.
  - out_valid=0, in_ready=1 once rst deasserts.
  - All payload outputs, err, instr_len and counters are 0.
  - Partially collected bytes are discarded.

Test Plan:
- Stream 0x66,0x89,0xD8 (last on D8) → one cycle later out_valid=1, unescaped_instr[23:0]=0x00D889, upper bytes 0, pfx_opsize=1, is_2byte=0, instr_len=3, err=0.
- Stream 0xF3,0x0F,0xB8,0xC1 (last) → is_2byte=1, pfx_rep=1, unescaped_instr[15:0]=0xC1B8, instr_len=4.
- Stream 0x2E,0x65,0x8B,0x00 (last) → pfx_seg=6 (GS wins over CS), body 0x008B; hold out_ready=0 for 5 cycles, then confirm outputs are stable and in_ready=0 throughout.
- Stream 0x66 with in_last=1 → out_valid with err=1. Then stream 0x0F alone (last) → err=1. Then 0x90 (last) → err=0, instr_len=1, body 0x90.
- Stream 16 bytes of 0x90 (last on the 16th) → in_ready held through drain, single out_valid with err=1. The next instruction 0xC3 decodes cleanly.
- Assert rst after 3 body bytes of an instruction → outputs 0 and state S_PFX. Next instruction 0x50 (last) → body 0x50, no residue from the aborted bytes.

Source files
------------

// File: rtl/decode_fetch_sequencer.sv
// Byte-serial x86 front end: strips legacy prefixes, detects the 0x0F escape and
// packs the remaining body bytes into one instruction per valid/ready handshake.
module decode_fetch_sequencer #(
    parameter int MAX_LEN    = 15,
    parameter int BODY_BYTES = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_byte,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*BODY_BYTES-1:0] unescaped_instr,
    output logic                    is_2byte,
    output logic                    pfx_opsize,
    output logic                    pfx_addrsize,
    output logic                    pfx_lock,
    output logic [1:0]              pfx_rep,
    output logic [2:0]              pfx_seg,
    output logic [3:0]              instr_len,
    output logic                    err
);
    localparam int CW = $clog2(BODY_BYTES + 1);

    typedef enum logic [1:0] {S_PFX, S_BODY, S_DRAIN, S_HOLD} state_e;

    state_e                         state_q, state_d;
    logic [BODY_BYTES-1:0][7:0]     body_q, body_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [3:0]                     len_q, len_d;
    logic                           err_q, err_d, esc_q, esc_d;
    logic                           os_q, os_d, as_q, as_d, lk_q, lk_d;
    logic [1:0]                     rep_q, rep_d;
    logic [2:0]                     seg_q, seg_d;
    logic                           acc, out_xfer, is_pfx, is_esc, over_cnt, bad_now;

    assign acc      = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign is_esc   = (in_byte == 8'h0F);

    always_comb begin
        is_pfx = 1'b0;
        case (in_byte)
            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_pfx = 1'b1;
            default: ;
        endcase
    end

    // A byte is bad if it is the (MAX_LEN+1)th, overflows the body buffer,
    // or ends the instruction before any opcode byte was seen.
    assign over_cnt = (len_q == 4'(MAX_LEN)) ||
                      (state_q == S_BODY && cnt_q == CW'(BODY_BYTES));
    assign bad_now  = acc && (state_q != S_DRAIN) &&
                      (over_cnt || (state_q == S_PFX && in_last && (is_pfx || is_esc)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PFX;
            body_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            esc_q   <= 1'b0;
            os_q    <= 1'b0;
            as_q    <= 1'b0;
            lk_q    <= 1'b0;
            rep_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            body_q  <= body_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            esc_q   <= esc_d;
            os_q    <= os_d;
            as_q    <= as_d;
            lk_q    <= lk_d;
            rep_q   <= rep_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PFX, S_BODY, S_DRAIN: begin
                if (acc) begin
                    if (in_last)                          state_d = S_HOLD;
                    else if (bad_now)                     state_d = S_DRAIN;
                    else if (state_q == S_PFX && !is_pfx) state_d = S_BODY;
                end
            end
            S_HOLD:  if (out_xfer) state_d = S_PFX;
            default: state_d = S_PFX;
        endcase
    end

    always_comb begin
        body_d = body_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        err_d  = err_q;
        esc_d  = esc_q;
        os_d   = os_q;
        as_d   = as_q;
        lk_d   = lk_q;
        rep_d  = rep_q;
        seg_d  = seg_q;
        if (out_xfer) begin
            body_d = '0;
            cnt_d  = '0;
            len_d  = '0;
            err_d  = 1'b0;
            esc_d  = 1'b0;
            os_d   = 1'b0;
            as_d   = 1'b0;
            lk_d   = 1'b0;
            rep_d  = '0;
            seg_d  = '0;
        end else if (acc) begin
            if (len_q != 4'd15) len_d = len_q + 4'd1;
            if (bad_now) begin
                err_d = 1'b1;
            end else if (state_q == S_PFX) begin
                if (is_pfx) begin
                    case (in_byte)
                        8'h66:   os_d  = 1'b1;
                        8'h67:   as_d  = 1'b1;
                        8'hF0:   lk_d  = 1'b1;
                        8'hF3:   rep_d = 2'd1;
                        8'hF2:   rep_d = 2'd2;
                        8'h26:   seg_d = 3'd1;
                        8'h2E:   seg_d = 3'd2;
                        8'h36:   seg_d = 3'd3;
                        8'h3E:   seg_d = 3'd4;
                        8'h64:   seg_d = 3'd5;
                        default: seg_d = 3'd6;
                    endcase
                end else if (is_esc) begin
                    esc_d = 1'b1;
                end else begin
                    body_d[0] = in_byte;
                    cnt_d     = CW'(1);
                end
            end else if (state_q == S_BODY) begin
                for (int k = 0; k < BODY_BYTES; k++)
                    if (cnt_q == CW'(k)) body_d[k] = in_byte;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        in_ready  = (state_q != S_HOLD);
        out_valid = (state_q == S_HOLD);
    end

    assign unescaped_instr = body_q;
    assign is_2byte        = esc_q;
    assign pfx_opsize      = os_q;
    assign pfx_addrsize    = as_q;
    assign pfx_lock        = lk_q;
    assign pfx_rep         = rep_q;
    assign pfx_seg         = seg_q;
    assign instr_len       = len_q;
    assign err             = err_q;
endmodule

// File: tb/tb_decode_fetch_sequencer.sv
// Directed bench: expected packed instructions are queued as bytes are streamed
// and popped when the sequencer presents out_valid.
module tb_decode_fetch_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, out_valid, is_2byte, pfx_opsize, pfx_addrsize, pfx_lock, err;
    logic [87:0] unescaped_instr;
    logic [1:0]  pfx_rep;
    logic [2:0]  pfx_seg;
    logic [3:0]  instr_len;

    int total = 0, bad = 0;

    typedef struct {
        logic [87:0] body;
        logic        is2, os, as_, lk;
        logic [1:0]  rep;
        logic [2:0]  seg;
        logic [3:0]  len;
        logic        err;
    } exp_t;
    exp_t sb[$];

    decode_fetch_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .unescaped_instr(unescaped_instr),
        .is_2byte(is_2byte), .pfx_opsize(pfx_opsize), .pfx_addrsize(pfx_addrsize),
        .pfx_lock(pfx_lock), .pfx_rep(pfx_rep), .pfx_seg(pfx_seg),
        .instr_len(instr_len), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [87:0] body, input logic is2, os, as_, lk,
                        input logic [1:0] rep, input logic [2:0] seg,
                        input logic [3:0] len, input logic e);
        exp_t x;
        x.body = body; x.is2 = is2; x.os = os; x.as_ = as_; x.lk = lk;
        x.rep = rep; x.seg = seg; x.len = len; x.err = e;
        sb.push_back(x);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1; in_byte = b; in_last = last;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            total++; bad++;
            $error("FAIL in_ready_timeout observed=0 expected=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called right after the last byte's acceptance edge: out_valid must already be up.
    task automatic collect(input int hold);
        exp_t        e;
        logic [87:0] snap;
        chk("latency_out_valid", 88'(out_valid), 88'd1);
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty observed=out_valid expected=none");
            return;
        end
        e = sb.pop_front();
        chk("err", 88'(err), 88'(e.err));
        if (!e.err) begin
            chk("body", unescaped_instr, e.body);
            chk("is_2byte", 88'(is_2byte), 88'(e.is2));
            chk("opsize", 88'(pfx_opsize), 88'(e.os));
            chk("addrsize", 88'(pfx_addrsize), 88'(e.as_));
            chk("lock", 88'(pfx_lock), 88'(e.lk));
            chk("rep", 88'(pfx_rep), 88'(e.rep));
            chk("seg", 88'(pfx_seg), 88'(e.seg));
            chk("instr_len", 88'(instr_len), 88'(e.len));
        end
        snap = unescaped_instr;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 88'(out_valid), 88'd1);
            chk("hold_in_ready", 88'(in_ready), 88'd0);
            chk("hold_body", unescaped_instr, snap);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_xfer_valid", 88'(out_valid), 88'd0);
        chk("post_xfer_in_ready", 88'(in_ready), 88'd1);
        chk("post_xfer_body", unescaped_instr, 88'd0);
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 88'(out_valid), 88'd0);
        chk("rst_in_ready", 88'(in_ready), 88'd1);
        chk("rst_body", unescaped_instr, 88'd0);
        chk("rst_len", 88'(instr_len), 88'd0);
        chk("rst_err", 88'(err), 88'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 66 89 D8
        push(88'h00D889, 0, 1, 0, 0, 0, 0, 4'd3, 0);
        send(8'h66, 0); send(8'h89, 0); send(8'hD8, 1);
        collect(0);

        // F3 0F B8 C1
        push(88'hC1B8, 1, 0, 0, 0, 1, 0, 4'd4, 0);
        send(8'hF3, 0); send(8'h0F, 0); send(8'hB8, 0); send(8'hC1, 1);
        collect(0);

        // CS then GS: last segment wins; output held 5 cycles
        push(88'h008B, 0, 0, 0, 0, 0, 3'd6, 4'd4, 0);
        send(8'h2E, 0); send(8'h65, 0); send(8'h8B, 0); send(8'h00, 1);
        collect(5);

        // F2 then F3: last rep wins, plus lock/addrsize/escape
        push(88'hC010, 1, 0, 1, 1, 2'd1, 0, 4'd7, 0);
        send(8'hF0, 0); send(8'hF2, 0); send(8'hF3, 0); send(8'h67, 0);
        send(8'h0F, 0); send(8'h10, 0); send(8'hC0, 1);
        collect(0);

        // No-opcode errors, then a clean one-byte instruction
        push('0, 0, 0, 0, 0, 0, 0, 0, 1);
        send(8'h66, 1); collect(0);
        push('0, 0, 0, 0, 0, 0, 0, 0, 1);
        send(8'h0F, 1); collect(0);
        push(88'h90, 0, 0, 0, 0, 0, 0, 4'd1, 0);
        send(8'h90, 1); collect(0);

        // Exactly MAX_LEN: 14 prefixes + opcode
        push(88'h90, 0, 1, 0, 0, 0, 0, 4'd15, 0);
        for (int i = 0; i < 14; i++) send(8'h66, 0);
        send(8'h90, 1); collect(0);

        // Exactly BODY_BYTES body bytes
        push(88'h0B0A090807060504030201, 0, 0, 0, 0, 0, 0, 4'd11, 0);
        for (int i = 1; i <= 11; i++) send(8'(i), i == 11);
        collect(0);

        // 16 bytes: overflow, drain, single error output
        push('0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            send(8'h90, i == 15);
            if (i < 15) chk("drain_no_valid", 88'(out_valid), 88'd0);
        end
        collect(0);
        push(88'hC3, 0, 0, 0, 0, 0, 0, 4'd1, 0);
        send(8'hC3, 1); collect(0);

        // Reset mid-instruction discards partial bytes
        send(8'h8B, 0); send(8'h45, 0); send(8'h08, 0);
        rst = 1'b1;
        #3;
        chk("midrst_body", unescaped_instr, 88'd0);
        chk("midrst_len", 88'(instr_len), 88'd0);
        chk("midrst_out_valid", 88'(out_valid), 88'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 88'(in_ready), 88'd1);
        push(88'h50, 0, 0, 0, 0, 0, 0, 4'd1, 0);
        send(8'h50, 1); collect(0);

        chk("scoreboard_drained", 88'(sb.size()), 88'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
